// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: streams DDR beats into banked weight buffers, GRP_W banks per beat, row by row.
// Optional WLOAD_BYTE_SWAP_EN reverses byte order within each DATA_LEN lane of the write data.
module weight_load_ctrl #(
  parameter int BUFFER_NUM   = 32,
  parameter int DATA_LEN     = 64,
  parameter int DDR_DATA_LEN = 256,
  parameter int ADDR_LEN     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_LEN-1:0]     cfg_base_addr,
  input  logic [ADDR_LEN-1:0]     cfg_rows,
  input  logic [DDR_DATA_LEN-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DDR_DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0]     wr_addr,
  output logic [BUFFER_NUM-1:0]   wr_en,
  output logic                    busy,
  output logic                    done
);
  localparam int GRP_W  = DDR_DATA_LEN / DATA_LEN;
  localparam int GROUPS = BUFFER_NUM / GRP_W;
  localparam int GCW    = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam int NB     = DATA_LEN / 8;
  localparam logic [BUFFER_NUM-1:0] GRP_MASK = BUFFER_NUM'({GRP_W{1'b1}});
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_LEN-1:0] base, rows, row_cnt;
  logic [GCW-1:0] grp_cnt;
  logic accept, grp_last, last;
  logic [DDR_DATA_LEN-1:0] s_data_fmt;
  assign accept   = s_valid && s_ready;
  assign grp_last = grp_cnt == GCW'(GROUPS - 1);
  assign last     = accept && grp_last && row_cnt == rows - 1'b1;
`ifdef WLOAD_BYTE_SWAP_EN
  always_comb begin
    s_data_fmt = s_data;
    for (int l = 0; l < GRP_W; l++)
      for (int b = 0; b < NB; b++)
        s_data_fmt[l*DATA_LEN + b*8 +: 8] = s_data[l*DATA_LEN + (NB-1-b)*8 +: 8];
  end
`else
  assign s_data_fmt = s_data;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : (cfg_rows == '0 ? DONE : LOAD);
      LOAD:    state_nx = last ? DONE : LOAD;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    s_ready = state == LOAD;
    busy    = state != IDLE;
    done    = state == DONE;
  end
  // Write outputs are registered: each accepted beat appears on the bank ports one cycle later.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      base    <= '0;
      rows    <= '0;
      row_cnt <= '0;
      grp_cnt <= '0;
      data_wr <= '0;
      wr_addr <= '0;
      wr_en   <= '0;
    end else begin
      if (state == IDLE && start && cfg_rows != '0) begin
        base    <= cfg_base_addr;
        rows    <= cfg_rows;
        row_cnt <= '0;
        grp_cnt <= '0;
      end
      if (accept) begin
        grp_cnt <= grp_last ? '0 : grp_cnt + 1'b1;
        row_cnt <= grp_last ? row_cnt + 1'b1 : row_cnt;
        data_wr <= s_data_fmt;
        wr_addr <= base + row_cnt;
      end
      wr_en <= accept ? GRP_MASK << (GRP_W * int'(grp_cnt)) : '0;
    end
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: directed scenario tests for weight_load_ctrl with hand-computed expectations.
module tb_weight_load_ctrl;
  logic clk = 0, rst = 1, start = 0, s_valid = 0;
  logic [15:0] cfg_base_addr = '0, cfg_rows = '0;
  logic [255:0] s_data = '0;
  logic s_ready, busy, done;
  logic [255:0] data_wr;
  logic [15:0] wr_addr;
  logic [31:0] wr_en;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  logic [15:0] log_addr[$];
  logic [31:0] log_en[$];
  logic [255:0] log_data[$];
  bit log_done[$];
  weight_load_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr), .cfg_rows(cfg_rows),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .data_wr(data_wr), .wr_addr(wr_addr),
    .wr_en(wr_en), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wr_en != 0) begin
      log_addr.push_back(wr_addr);
      log_en.push_back(wr_en);
      log_data.push_back(data_wr);
      log_done.push_back(done);
    end
    if (done) done_cnt++;
  end
  task automatic clear_log;
    log_addr.delete(); log_en.delete(); log_data.delete(); log_done.delete(); done_cnt = 0;
  endtask
  task automatic do_start(input logic [15:0] b, input logic [15:0] r);
    @(negedge clk);
    cfg_base_addr = b; cfg_rows = r; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done;
    for (int i = 0; i < 200 && done !== 1'b1; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL done_timeout: done=%b want 1", done); end
  endtask
  task automatic test_reset;
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, s_ready, wr_en, wr_addr, data_wr} !== '0)
      begin n_bad++; $display("FAIL reset_outputs: busy=%b done=%b rdy=%b en=%h addr=%h want all 0", busy, done, s_ready, wr_en, wr_addr); end
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 0 || s_ready !== 0) begin n_bad++; $display("FAIL reset_idle: busy=%b rdy=%b want 0 0", busy, s_ready); end
  endtask
  task automatic test_basic;
    logic [31:0] exp_en;
    logic [15:0] exp_a;
    clear_log();
    s_data = {4{64'hA5A5_0000_1111_2222}};
    s_valid = 1;
    do_start(16'h0010, 16'd2);
    n_cmp++;
    if (s_ready !== 1 || busy !== 1) begin n_bad++; $display("FAIL basic_ready: rdy=%b busy=%b want 1 1", s_ready, busy); end
    wait_done();
    s_valid = 0;
    n_cmp++;
    if (log_en.size() != 16) begin n_bad++; $display("FAIL basic_count: got %0d want 16", log_en.size()); end
    for (int k = 0; k < 16 && k < log_en.size(); k++) begin
      exp_en = 32'h0000_000F << (4 * (k % 8));
      exp_a = 16'h0010 + 16'(k / 8);
      n_cmp++;
      if (log_en[k] !== exp_en || log_addr[k] !== exp_a || log_done[k] !== (k == 15))
        begin n_bad++; $display("FAIL basic_write[%0d]: got addr %h en %h done %b want addr %h en %h done %b", k, log_addr[k], log_en[k], log_done[k], exp_a, exp_en, k == 15); end
    end
    n_cmp++;
    if (data_wr !== {4{64'hA5A5_0000_1111_2222}}) begin n_bad++; $display("FAIL basic_data: got %h", data_wr); end
    @(negedge clk); #1;
    n_cmp++;
    if (busy !== 0 || done !== 0 || wr_en !== 0 || done_cnt != 1)
      begin n_bad++; $display("FAIL basic_end: busy=%b done=%b en=%h pulses=%0d want 0 0 0 1", busy, done, wr_en, done_cnt); end
  endtask
  task automatic test_gaps;
    logic [31:0] exp_en;
    bit acc_prev;
    clear_log();
    s_valid = 0;
    do_start(16'h0020, 16'd1);
    acc_prev = 0;
    for (int i = 0; i < 60; i++) begin
      if (!acc_prev) begin
        n_cmp++;
        if (wr_en !== 0) begin n_bad++; $display("FAIL gap_en[%0d]: got %h want 0", i, wr_en); end
      end
      if (done === 1'b1) break;
      s_valid = (i % 2 == 0);
      acc_prev = s_valid && s_ready;
      @(negedge clk);
    end
    s_valid = 0;
    #1;
    n_cmp++;
    if (log_en.size() != 8 || done_cnt != 1) begin n_bad++; $display("FAIL gap_count: got %0d writes %0d pulses want 8 1", log_en.size(), done_cnt); end
    for (int k = 0; k < 8 && k < log_en.size(); k++) begin
      exp_en = 32'h0000_000F << (4 * k);
      n_cmp++;
      if (log_en[k] !== exp_en || log_addr[k] !== 16'h0020 || log_done[k] !== (k == 7))
        begin n_bad++; $display("FAIL gap_write[%0d]: got addr %h en %h done %b want addr 0020 en %h", k, log_addr[k], log_en[k], log_done[k], exp_en); end
    end
    @(negedge clk);
  endtask
  task automatic test_zero_rows;
    clear_log();
    s_valid = 1;
    do_start(16'h0033, 16'd0);
    n_cmp++;
    if (busy !== 1 || done !== 1 || s_ready !== 0 || wr_en !== 0)
      begin n_bad++; $display("FAIL zero_done: busy=%b done=%b rdy=%b en=%h want 1 1 0 0", busy, done, s_ready, wr_en); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 0 || done !== 0 || s_ready !== 0 || wr_en !== 0)
      begin n_bad++; $display("FAIL zero_idle: busy=%b done=%b rdy=%b en=%h want 0 0 0 0", busy, done, s_ready, wr_en); end
    s_valid = 0;
    @(negedge clk); #1;
    n_cmp++;
    if (log_en.size() != 0 || done_cnt != 1) begin n_bad++; $display("FAIL zero_writes: got %0d writes %0d pulses want 0 1", log_en.size(), done_cnt); end
  endtask
  task automatic test_wrap;
    clear_log();
    s_valid = 1;
    do_start(16'hFFFF, 16'd2);
    wait_done();
    s_valid = 0;
    n_cmp++;
    if (log_en.size() != 16) begin n_bad++; $display("FAIL wrap_count: got %0d want 16", log_en.size()); end
    else begin
      n_cmp++;
      if (log_addr[0] !== 16'hFFFF || log_addr[7] !== 16'hFFFF || log_addr[8] !== 16'h0000 || log_addr[15] !== 16'h0000)
        begin n_bad++; $display("FAIL wrap_addr: got %h %h %h %h want ffff ffff 0000 0000", log_addr[0], log_addr[7], log_addr[8], log_addr[15]); end
    end
    @(negedge clk);
  endtask
  task automatic test_abort;
    logic [31:0] exp_en;
    clear_log();
    s_valid = 1;
    do_start(16'h0040, 16'd3);
    for (int i = 0; i < 40 && log_en.size() < 5; i++) begin @(negedge clk); #1; end
    #1 rst = 1;
    #1;
    n_cmp++;
    if ({busy, done, s_ready, wr_en, wr_addr, data_wr} !== '0)
      begin n_bad++; $display("FAIL abort_outputs: busy=%b done=%b rdy=%b en=%h addr=%h want all 0", busy, done, s_ready, wr_en, wr_addr); end
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (log_en.size() != 5 || done_cnt != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d writes %0d pulses want 5 0", log_en.size(), done_cnt); end
    clear_log();
    do_start(16'h0050, 16'd1);
    wait_done();
    s_valid = 0;
    n_cmp++;
    if (log_en.size() != 8 || done_cnt != 1) begin n_bad++; $display("FAIL abort_reload_count: got %0d writes %0d pulses want 8 1", log_en.size(), done_cnt); end
    for (int k = 0; k < 8 && k < log_en.size(); k++) begin
      exp_en = 32'h0000_000F << (4 * k);
      n_cmp++;
      if (log_en[k] !== exp_en || log_addr[k] !== 16'h0050)
        begin n_bad++; $display("FAIL abort_reload[%0d]: got addr %h en %h want addr 0050 en %h", k, log_addr[k], log_en[k], exp_en); end
    end
    @(negedge clk);
  endtask
  task automatic test_restart_ignored;
    logic [255:0] exp_data;
`ifdef WLOAD_BYTE_SWAP_EN
    exp_data = {4{64'h0807_0605_0403_0201}};
`else
    exp_data = {4{64'h0102_0304_0506_0708}};
`endif
    clear_log();
    s_data = {4{64'h0102_0304_0506_0708}};
    s_valid = 1;
    do_start(16'h0060, 16'd1);
    @(negedge clk);
    cfg_base_addr = 16'h0070; cfg_rows = 16'd4; start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    s_valid = 0;
    n_cmp++;
    if (log_en.size() != 8) begin n_bad++; $display("FAIL restart_count: got %0d want 8", log_en.size()); end
    for (int k = 0; k < 8 && k < log_en.size(); k++) begin
      n_cmp++;
      if (log_addr[k] !== 16'h0060 || log_data[k] !== exp_data)
        begin n_bad++; $display("FAIL restart_write[%0d]: got addr %h data %h want addr 0060 data %h", k, log_addr[k], log_data[k][63:0], exp_data[63:0]); end
    end
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (busy !== 0 || done_cnt != 1 || log_en.size() != 8)
      begin n_bad++; $display("FAIL restart_end: busy=%b pulses=%0d writes=%0d want 0 1 8", busy, done_cnt, log_en.size()); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_rows();
    test_wrap();
    test_abort();
    test_restart_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 SHALL have parameter BUFFER_NUM, default 32: number of weight buffer banks, each with its own write-enable bit.
REQ-002 SHALL have parameter DATA_LEN, default 64: width of one bank word in bits.
REQ-003 SHALL have parameter DDR_DATA_LEN, default 256: width of one incoming DDR beat; GRP_W = DDR_DATA_LEN/DATA_LEN (4); GROUPS = BUFFER_NUM/GRP_W (8).
REQ-004 SHALL have parameter ADDR_LEN, default 16: bank address width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1: one-cycle load request.
REQ-008 SHALL have port cfg_base_addr, input, ADDR_LEN: first bank row to write.
REQ-009 SHALL have port cfg_rows, input, ADDR_LEN: number of bank rows to load.
REQ-010 SHALL have port s_data, input, DDR_DATA_LEN: DDR beat payload.
REQ-011 SHALL have port s_valid, input, 1: the beat is valid.
REQ-012 SHALL have port s_ready, output, 1: the block accepts the beat.
REQ-013 SHALL have port data_wr, output, DDR_DATA_LEN: write data, broadcast to all bank groups.
REQ-014 SHALL have port wr_addr, output, ADDR_LEN: write row, shared by all banks.
REQ-015 SHALL have port wr_en, output, BUFFER_NUM: per-bank write enables.
REQ-016 SHALL have port busy, output, 1: a load is in progress.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when a load completes.

Function
REQ-018 SHALL implement states IDLE, LOAD and DONE.
REQ-019 IDLE->LOAD on start with cfg_rows!=0: latch base/rows, clear grp_cnt and row_cnt.
REQ-020 IDLE->DONE on start with cfg_rows==0; no write occurs.
REQ-021 DONE->IDLE unconditionally after one cycle; done=1 exactly while in DONE.
REQ-022 s_ready=1 iff state==LOAD, decoded combinationally from the state register.
REQ-023 Beat accepted when s_valid&&s_ready; the next cycle drives data_wr=s_data, wr_addr=base+row_cnt (mod 2^ADDR_LEN), wr_en bits [grp_cnt*GRP_W +: GRP_W]=1, all others 0.
REQ-024 wr_en SHALL be all-zero in every cycle that follows a non-accepted cycle; data_wr and wr_addr hold their last values.
REQ-025 Per accepted beat: grp_cnt increments; at GROUPS-1 it wraps to 0 and row_cnt increments.
REQ-026 Accepting the beat with grp_cnt==GROUPS-1 and row_cnt==rows-1 SHALL move LOAD->DONE; the final write and done are in the same cycle.
REQ-027 busy=1 in LOAD and DONE, 0 in IDLE.
REQ-028 start outside IDLE SHALL be ignored; latched config is unchanged.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_LEN (base 0xFFFF, row 1 -> 0x0000).
REQ-030 Total writes per load = cfg_rows*GROUPS; s_valid gaps SHALL stall without losing position.

Reset
REQ-031 rst asynchronously forces state=IDLE, grp_cnt=0, row_cnt=0, wr_en=0, wr_addr=0, data_wr=0, done=0, busy=0, s_ready=0.
REQ-032 rst during LOAD SHALL abort the load with no further writes and no done pulse; the next start begins a fresh load.

Configuration
REQ-033 With WLOAD_BYTE_SWAP_EN defined, data_wr SHALL equal s_data with byte order reversed within each DATA_LEN lane (byte 0 <-> byte 7 for a 64-bit lane); without it, data_wr = s_data unmodified.

Verification
REQ-034 start, base=0x0010, rows=2, s_valid held 1 -> 16 writes: wr_addr 0x0010 with wr_en 0x0000000F, 0x000000F0, ..., 0xF0000000, then 0x0011 over the same sequence; done in the cycle of the last write.
REQ-035 s_valid toggled 1/0 during rows=1 -> 8 writes with wr_en zero in each gap cycle; group order intact; done after the 8th write.
REQ-036 start with rows=0 -> busy=1 for one cycle, done=1 in that cycle, wr_en never nonzero, s_ready stays 0.
REQ-037 base=0xFFFF, rows=2 -> second row written at wr_addr 0x0000.
REQ-038 rst asserted after 5 beats -> all outputs 0 immediately; no done pulse; a new start with rows=1 yields 8 clean writes.
REQ-039 Second start during LOAD -> ignored; write count and addresses match the first configuration; with WLOAD_BYTE_SWAP_EN, s_data lane 0 = 0x0102030405060708 -> data_wr lane 0 = 0x0807060504030201.
